// File: rtl/font_access_ctrl_pkg.sv
// Shared font memory geometry and the access controller's state encoding.
// The BRAM, the video fetch and the host interface all import these constants.
package font_access_ctrl_pkg;

  localparam int FONT_ADDR_W = 13;
  localparam int FONT_DATA_W = 8;
  localparam int STALL_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_DATA  = 2'd3
  } fac_state_t;

endpackage

// File: rtl/font_access_ctrl.sv
// Font BRAM port arbiter: video owns the read port, host reads slip into idle
// slots or steal one after STALL_MAX cycles, host writes use the write port freely.
module font_access_ctrl
  import font_access_ctrl_pkg::*;
#(
  parameter int ADDR_W    = FONT_ADDR_W,
  parameter int DATA_W    = FONT_DATA_W,
  parameter int STALL_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_rd_en,
  input  logic [ADDR_W-1:0] vid_rd_addr,
  output logic              vid_grant,
  output logic              vid_rd_valid,
  output logic [DATA_W-1:0] vid_rd_data,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_busy,
  output logic [ADDR_W-1:0] font_rd_addr,
  input  logic [DATA_W-1:0] font_rd_data,
  output logic              font_wr_en,
  output logic [ADDR_W-1:0] font_wr_addr,
  output logic [DATA_W-1:0] font_wr_data
);

  localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(STALL_MAX - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_SAT  = '1;

  fac_state_t              state;
  fac_state_t              state_next;
  logic [ADDR_W-1:0]       hold_addr;
  logic [DATA_W-1:0]       hold_wdata;
  logic [DATA_W-1:0]       rdata_q;
  logic [STALL_CNT_W-1:0]  stall_cnt;
  logic                    issuing;

  // Reset suppresses the ack/write strobes so an interrupted write never lands.
  always_comb begin
    state_next   = state;
    issuing      = (state == RD_WAIT) && (!vid_rd_en || (stall_cnt == STALL_LAST));
    vid_grant    = !issuing;
    font_rd_addr = issuing ? hold_addr : vid_rd_addr;
    font_wr_en   = (state == WR_ISSUE) && !reset;
    font_wr_addr = hold_addr;
    font_wr_data = hold_wdata;
    host_ack     = ((state == WR_ISSUE) || (state == RD_DATA)) && !reset;
    host_busy    = (state != IDLE);
    host_rdata   = ((state == RD_DATA) && !reset) ? font_rd_data : rdata_q;
    vid_rd_data  = font_rd_data;

    case (state)
      IDLE:     if (host_req) state_next = host_wr ? WR_ISSUE : RD_WAIT;
      WR_ISSUE: state_next = IDLE;
      RD_WAIT:  if (issuing) state_next = RD_DATA;
      RD_DATA:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      stall_cnt    <= '0;
      rdata_q      <= '0;
      vid_rd_valid <= 1'b0;
      hold_addr    <= '0;
      hold_wdata   <= '0;
    end else begin
      state        <= state_next;
      vid_rd_valid <= vid_rd_en && vid_grant;

      if ((state == IDLE) && host_req) begin
        hold_addr  <= host_addr;
        hold_wdata <= host_wdata;
        stall_cnt  <= '0;
      end else if ((state == RD_WAIT) && !issuing && (stall_cnt != STALL_SAT)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      // The ack cycle bypasses the BRAM byte; the register keeps it afterwards.
      if (state == RD_DATA) rdata_q <= font_rd_data;
    end
  end

endmodule

// File: tb/tb_font_access_ctrl.sv
// Bench for font_access_ctrl: BRAM model, directed reset cases, then segments of
// patterned/random video traffic with host ops checked against a transaction-level model.
module tb_font_access_ctrl;
  import font_access_ctrl_pkg::*;

  localparam int AW   = FONT_ADDR_W;
  localparam int DW   = FONT_DATA_W;
  localparam int SM   = 4;
  localparam int NMAX = 3000;

  logic          clk;
  logic          reset;
  logic          vid_rd_en;
  logic [AW-1:0] vid_rd_addr;
  logic          vid_grant;
  logic          vid_rd_valid;
  logic [DW-1:0] vid_rd_data;
  logic          host_req;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_busy;
  logic [AW-1:0] font_rd_addr;
  logic [DW-1:0] font_rd_data;
  logic          font_wr_en;
  logic [AW-1:0] font_wr_addr;
  logic [DW-1:0] font_wr_data;

  font_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STALL_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .vid_rd_en(vid_rd_en), .vid_rd_addr(vid_rd_addr), .vid_grant(vid_grant),
    .vid_rd_valid(vid_rd_valid), .vid_rd_data(vid_rd_data),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_busy(host_busy), .font_rd_addr(font_rd_addr), .font_rd_data(font_rd_data),
    .font_wr_en(font_wr_en), .font_wr_addr(font_wr_addr), .font_wr_data(font_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Font BRAM: one-cycle read latency, read-before-write on collisions.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int wr_pulses = 0;
  always @(posedge clk) begin
    if (font_wr_en) begin
      mem[font_wr_addr] <= font_wr_data;
      wr_pulses++;
    end
    font_rd_data <= mem[font_rd_addr];
  end

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;
  } host_op_t;

  host_op_t      op_q[$];
  bit            vid_en  [0:NMAX-1];
  logic [AW-1:0] vid_adr [0:NMAX-1];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_writes = 0;
  bit            h_active = 1'b0;
  host_op_t      h_op;
  int            h_start, h_issue, h_ack, h_ready;
  logic [DW-1:0] last_rdata;
  bit            prev_vgrant;
  logic [DW-1:0] pv_old, pv_new;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic pushOp(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int gap);
    host_op_t op;
    op.wr = wr; op.addr = addr; op.data = data; op.gap = gap;
    op_q.push_back(op);
  endtask

  // One clock cycle: drive inputs, predict outputs from the access rules, then retire.
  task automatic runCycle(input bit allow_start);
    bit            exp_grant;
    bit            is_ack;
    logic [AW-1:0] exp_raddr;
    logic [DW-1:0] exp_vdata;
    vid_rd_en   = vid_en[cyc];
    vid_rd_addr = vid_adr[cyc];
    if (!h_active && allow_start && cyc >= h_ready && op_q.size() > 0) begin
      h_op     = op_q.pop_front();
      h_active = 1'b1;
      h_start  = cyc;
      if (h_op.wr) begin
        h_issue = -1;
        h_ack   = cyc + 1;
      end else begin
        h_issue = cyc + SM;
        for (int k = 1; k <= SM; k++) begin
          if (!vid_en[cyc + k]) begin
            h_issue = cyc + k;
            break;
          end
        end
        h_ack = h_issue + 1;
      end
    end
    host_req   = h_active;
    host_wr    = h_op.wr;
    host_addr  = h_op.addr;
    host_wdata = h_op.data;

    @(negedge clk);
    is_ack    = h_active && (cyc == h_ack);
    exp_grant = !(h_active && (cyc == h_issue));
    exp_raddr = exp_grant ? vid_adr[cyc] : h_op.addr;
    checkOutput("vid_grant", 32'(vid_grant), 32'(exp_grant));
    checkOutput("font_rd_addr", 32'(font_rd_addr), 32'(exp_raddr));
    checkOutput("host_ack", 32'(host_ack), 32'(is_ack));
    checkOutput("font_wr_en", 32'(font_wr_en), 32'(is_ack && h_op.wr));
    if (is_ack && h_op.wr) begin
      checkOutput("font_wr_addr", 32'(font_wr_addr), 32'(h_op.addr));
      checkOutput("font_wr_data", 32'(font_wr_data), 32'(h_op.data));
    end
    checkOutput("host_busy", 32'(host_busy), 32'(h_active && (cyc > h_start)));
    checkOutput("host_rdata", 32'(host_rdata),
                32'((is_ack && !h_op.wr) ? ref_mem[h_op.addr] : last_rdata));
    checkOutput("vid_rd_valid", 32'(vid_rd_valid), 32'(prev_vgrant));
    if (prev_vgrant) begin
      exp_vdata = (vid_rd_data === pv_new) ? pv_new : pv_old;
      checkOutput("vid_rd_data", 32'(vid_rd_data), 32'(exp_vdata));
    end

    @(posedge clk);
    #1;
    prev_vgrant = vid_en[cyc] && exp_grant;
    pv_old      = ref_mem[vid_adr[cyc]];
    pv_new      = pv_old;
    if (is_ack) begin
      if (h_op.wr) begin
        if (h_op.addr == vid_adr[cyc]) pv_new = h_op.data;
        ref_mem[h_op.addr] = h_op.data;
        n_writes++;
      end else begin
        last_rdata = ref_mem[h_op.addr];
      end
      h_active = 1'b0;
      h_ready  = cyc + 1 + h_op.gap;
    end
    cyc++;
  endtask

  // mode: 0 video idle, 1 video held high, 2 sequential stream, 3 toggling, 4 random
  task automatic applyStimulus(input int mode, input int ncyc);
    int guard;
    for (int i = 0; i < ncyc + 16; i++) begin
      automatic int c = cyc + i;
      if (c < NMAX) begin
        case (mode)
          0:       vid_en[c] = 1'b0;
          1, 2:    vid_en[c] = 1'b1;
          3:       vid_en[c] = (i % 2 == 0);
          default: vid_en[c] = ($urandom_range(0, 9) < 7);
        endcase
        vid_adr[c] = (mode == 2) ? AW'(i) : AW'($urandom);
      end
    end
    for (int i = 0; i < ncyc; i++) runCycle(1'b1);
    guard = 0;
    while (h_active && guard < 20) begin
      runCycle(1'b0);
      guard++;
    end
    op_q.delete();
  endtask

  initial begin
    reset = 1'b1; vid_rd_en = 1'b0; vid_rd_addr = '0; host_req = 1'b0;
    host_wr = 1'b0; host_addr = '0; host_wdata = '0;
    h_op.wr = 1'b0; h_op.addr = '0; h_op.data = '0; h_op.gap = 0;
    h_start = 0; h_issue = -1; h_ack = -1; h_ready = 0;
    last_rdata = '0; prev_vgrant = 1'b0; pv_old = '0; pv_new = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_vid_rd_valid", 32'(vid_rd_valid), 32'd0);
    checkOutput("rst_host_ack", 32'(host_ack), 32'd0);
    checkOutput("rst_host_rdata", 32'(host_rdata), 32'd0);
    checkOutput("rst_host_busy", 32'(host_busy), 32'd0);
    checkOutput("rst_font_wr_en", 32'(font_wr_en), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset while a host read of 0x0123 waits behind busy video.
    vid_rd_en = 1'b1; vid_rd_addr = AW'($urandom);
    host_req = 1'b1; host_wr = 1'b0; host_addr = AW'(13'h0123);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rdwait_busy", 32'(host_busy), 32'd1);
    checkOutput("rdwait_grant", 32'(vid_grant), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; host_req = 1'b0;
    @(negedge clk);
    checkOutput("rstrd_busy", 32'(host_busy), 32'd0);
    checkOutput("rstrd_ack", 32'(host_ack), 32'd0);
    checkOutput("rstrd_wr_en", 32'(font_wr_en), 32'd0);

    // Reset arriving in the write-issue cycle must drop the write.
    vid_rd_en = 1'b0;
    host_req = 1'b1; host_wr = 1'b1; host_addr = AW'(13'h0555);
    host_wdata = ~ref_mem[13'h0555];
    @(posedge clk);
    #1 reset = 1'b1; host_req = 1'b0;
    @(negedge clk);
    checkOutput("rstwr_wr_en", 32'(font_wr_en), 32'd0);
    checkOutput("rstwr_ack", 32'(host_ack), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rstwr_busy", 32'(host_busy), 32'd0);
    checkOutput("rst_wr_pulses", 32'(wr_pulses), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] directed ops with idle video");
    pushOp(1'b1, AW'(13'h1000), 8'hA5, 1);
    pushOp(1'b0, AW'(13'h1000), 8'h00, 0);
    pushOp(1'b0, AW'(13'h0041), 8'h00, 1);
    pushOp(1'b0, AW'(13'h0555), 8'h00, 0);
    applyStimulus(0, 20);

    $display("[TB] host reads behind continuous video");
    pushOp(1'b0, AW'(13'h0200), 8'h00, 1);
    pushOp(1'b0, AW'($urandom), 8'h00, 0);
    pushOp(1'b1, AW'($urandom), DW'($urandom), 0);
    pushOp(1'b0, AW'($urandom), 8'h00, 2);
    applyStimulus(1, 30);

    $display("[TB] video stream 0x000..0x0FF with host writes");
    for (int i = 0; i < 16; i++)
      pushOp(1'b1, AW'($urandom_range(0, 255)), DW'($urandom), $urandom_range(0, 12));
    applyStimulus(2, 256);

    $display("[TB] toggling video with host reads");
    for (int i = 0; i < 6; i++)
      pushOp(1'b0, AW'($urandom), 8'h00, $urandom_range(0, 2));
    applyStimulus(3, 40);

    $display("[TB] random mixed traffic");
    for (int i = 0; i < 120; i++)
      pushOp(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), DW'($urandom),
             $urandom_range(0, 3));
    applyStimulus(4, 600);

    checkOutput("write_pulse_count", 32'(wr_pulses), 32'(n_writes));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
